// File: rtl/line_mem_pkg.sv
// Shared types and widths for the line memory responder.
// Optional feature macro: RESP_CWF_EN (critical-word-first read ordering).
package line_mem_pkg;

  // Default geometry: 64 words, 4 words per line
  localparam int DEPTH_DEF     = 64;
  localparam int BLK_WORDS_DEF = 4;
  localparam int BLK_W         = $clog2(DEPTH_DEF / BLK_WORDS_DEF);
  localparam int OFF_W         = $clog2(BLK_WORDS_DEF);

  // Latency counter covers LATENCY values 1..15
  localparam int CNT_W = $clog2(16);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WDATA  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RBURST = 2'd3
  } line_state_e;

endpackage

// File: rtl/line_mem_responder_word_ram.sv
// Single-port word storage: synchronous read, write enable, and an
// asynchronous reset that loads memory[i] = i. The read register is cleared
// whenever no read is requested so the data output idles at zero.
module word_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int A_W    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [A_W-1:0]    addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage array: identity init on reset, write on enable
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_W'(i);
      end
    end else if (we) begin
      mem_r[addr] <= wdata;
    end else begin
      mem_r[addr] <= mem_r[addr];
    end
  end

  // Registered read port, zero when not reading
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= '0;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/line_mem_responder.sv
// Line-granular memory responder: accepts line fills and write-backs,
// waits a fixed latency, then streams read beats or acknowledges the write.
// Optional feature macro: RESP_CWF_EN -- when defined, fill beats start at
// the requested critical word and wrap within the line.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int BLK_WORDS = 4,
  parameter int LATENCY   = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_we,
  input  logic [$clog2(DEPTH/BLK_WORDS)-1:0] req_blk,
  input  logic [$clog2(BLK_WORDS)-1:0]       req_word,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [DATA_W-1:0]                  rsp_data,
  output logic                               rsp_last,
  output logic                               wr_ack
);

  localparam int LB_W = $clog2(DEPTH / BLK_WORDS);
  localparam int LO_W = $clog2(BLK_WORDS);
  localparam int A_W  = LB_W + LO_W;
  localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [LO_W-1:0]  LAST_BEAT = LO_W'(BLK_WORDS - 1);
`ifdef RESP_CWF_EN
  localparam logic CWF_EN = 1'b1;
`else
  localparam logic CWF_EN = 1'b0;
`endif

  line_state_e       state_r, state_s;
  logic              we_r, we_s;
  logic [LB_W-1:0]   blk_r;
  logic [LO_W-1:0]   word_r, off_s, word_sel_s;
  logic [LO_W-1:0]   beat_r, beat_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              accept_s, ram_we_s, ram_re_s;
  logic [A_W-1:0]    ram_addr_s;
  logic              wr_ready_r, rsp_valid_r, rsp_last_r, wr_ack_r;

  // Next-state, beat counter and latency counter
  always_comb begin
    state_s  = state_r;
    beat_s   = beat_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    ram_we_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          beat_s   = '0;
          if (req_we) begin
            state_s = ST_WDATA;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = LAT_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (wr_valid) begin
          ram_we_s = 1'b1;
          beat_s   = beat_r + 1'b1;
          if (beat_r == LAST_BEAT) begin
            state_s = ST_WAIT;
            cnt_s   = LAT_LOAD;
          end else begin
            state_s = ST_WDATA;
          end
        end else begin
          state_s = ST_WDATA;
        end
      end
      ST_WAIT: begin
        if (cnt_r == '0) begin
          beat_s  = '0;
          state_s = we_r ? ST_IDLE : ST_RBURST;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      ST_RBURST: begin
        if (rsp_ready) begin
          beat_s  = beat_r + 1'b1;
          state_s = (beat_r == LAST_BEAT) ? ST_IDLE : ST_RBURST;
        end else begin
          state_s = ST_RBURST;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // RAM address: writes walk the line in order; reads prefetch the beat that
  // will be on the bus next cycle so the registered read lines up with rsp_valid
  always_comb begin
    we_s  = accept_s ? req_we : we_r;
    off_s = word_r & {LO_W{CWF_EN}};
    if (state_r == ST_WDATA) begin
      word_sel_s = beat_r;
    end else begin
      word_sel_s = off_s + beat_s;
    end
    ram_addr_s = {blk_r, word_sel_s};
    ram_re_s   = (state_s == ST_RBURST);
  end

  // FSM state, latched request fields and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      we_r    <= 1'b0;
      blk_r   <= '0;
      word_r  <= '0;
      beat_r  <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        we_r   <= req_we;
        blk_r  <= req_blk;
        word_r <= req_word;
      end else begin
        we_r   <= we_r;
        blk_r  <= blk_r;
        word_r <= word_r;
      end
    end
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ready_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      wr_ack_r    <= 1'b0;
    end else begin
      wr_ready_r  <= (state_s == ST_WDATA);
      rsp_valid_r <= (state_s == ST_RBURST);
      rsp_last_r  <= (state_s == ST_RBURST) && (beat_s == LAST_BEAT);
      wr_ack_r    <= (state_s == ST_WAIT) && we_s && (cnt_s == '0);
    end
  end

  word_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .A_W    (A_W)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .addr  (ram_addr_s),
    .wdata (wr_data),
    .rdata (rsp_data)
  );

  assign req_ready = (state_r == ST_IDLE);
  assign wr_ready  = wr_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_last  = rsp_last_r;
  assign wr_ack    = wr_ack_r;

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder with a word-array reference model.
module tb_line_mem_responder;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int BW     = 4;
  localparam int LAT    = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_blk = 4'd0;
  logic [1:0]  req_word = 2'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        wr_ack;

  int tests = 0;
  int fails = 0;
  logic [31:0] mem_m [DEPTH];

  line_mem_responder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .BLK_WORDS(BW), .LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_blk(req_blk), .req_word(req_word),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .wr_ack(wr_ack)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'(i);
  endtask

  function automatic logic [31:0] exp_word(input int blk, input int word, input int n);
`ifdef RESP_CWF_EN
    return mem_m[blk * BW + ((word + n) % BW)];
`else
    return mem_m[blk * BW + n];
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_wr_ready"},  32'(wr_ready),  32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_last"},  32'(rsp_last),  32'd0);
    check({tag, "_wr_ack"},    32'(wr_ack),    32'd0);
    check({tag, "_rsp_data"},  rsp_data,       32'd0);
  endtask

  // Present a request at a negedge; returns at the negedge of cycle 1 after accept
  task automatic issue(input bit we, input int blk, input int word);
    check("req_ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_blk   = 4'(blk);
    req_word  = 2'(word);
    @(negedge clock);
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_blk   = 4'($urandom_range(0, 15));
    req_word  = 2'($urandom_range(0, 3));
    check("busy_after_accept", 32'(req_ready), 32'd0);
  endtask

  // Collect a fill starting at the negedge of cycle 1 after accept
  task automatic collect_fill(input int blk, input int word, input int stall_beat,
                              input int stall_len, input bit hold_next,
                              input int nblk, input int nword);
    int cyc;
    logic [31:0] exp;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      wr_valid  = 1'($urandom_range(0, 1));
      wr_data   = $urandom;
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      cyc++;
    end
    wr_valid = 1'b0;
    check("fill_latency", 32'(cyc), 32'(LAT + 1));
    if (hold_next) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_blk   = 4'(nblk);
      req_word  = 2'(nword);
    end
    for (int n = 0; n < BW; n++) begin
      exp = exp_word(blk, word, n);
      for (int s = 0; s < ((n == stall_beat) ? stall_len : 0); s++) begin
        rsp_ready = 1'b0;
        check("stall_valid", 32'(rsp_valid), 32'd1);
        check("stall_hold", rsp_data, exp);
        @(negedge clock);
      end
      rsp_ready = 1'b1;
      check("beat_valid", 32'(rsp_valid), 32'd1);
      check("beat_data", rsp_data, exp);
      check("beat_last", 32'(rsp_last), 32'(n == BW - 1));
      if (hold_next) check("busy_req_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
    end
    check("fill_done_valid", 32'(rsp_valid), 32'd0);
    check("fill_done_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'($urandom_range(0, 1));
    if (hold_next) begin
      @(negedge clock);
      req_valid = 1'b0;
      check("held_req_accepted", 32'(req_ready), 32'd0);
    end
  endtask

  task automatic do_write(input int blk, input logic [31:0] d [BW]);
    int cyc;
    issue(1'b1, blk, $urandom_range(0, 3));
    check("wdata_ready", 32'(wr_ready), 32'd1);
    for (int k = 0; k < BW; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        wr_valid = 1'b0;
        @(negedge clock);
      end
      check("wdata_ready_beat", 32'(wr_ready), 32'd1);
      wr_valid  = 1'b1;
      wr_data   = d[k];
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      mem_m[blk * BW + k] = d[k];
    end
    wr_valid = 1'b0;
    cyc = 1;
    while (!wr_ack && cyc < 40) begin
      check("wait_wr_ready", 32'(wr_ready), 32'd0);
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = $urandom;
      @(negedge clock);
      cyc++;
    end
    wr_valid = 1'b0;
    check("wr_ack_latency", 32'(cyc), 32'(LAT));
    @(negedge clock);
    check("wr_ack_pulse", 32'(wr_ack), 32'd0);
    check("wr_done_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d [BW];
    int blk;
    int word;

    // Reset state
    model_reset();
    #1;
    check_idle("in_reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    check_idle("after_reset");

    // Plain fill of line 2
    issue(1'b0, 2, 0);
    collect_fill(2, 0, -1, 0, 1'b0, 0, 0);

    // Write-back of line 1, then read it back
    d = '{32'd100, 32'd101, 32'd102, 32'd103};
    do_write(1, d);
    issue(1'b0, 1, 0);
    collect_fill(1, 0, -1, 0, 1'b0, 0, 0);

    // Backpressure on beat 1 of line 0
    issue(1'b0, 0, 0);
    collect_fill(0, 0, 1, 2, 1'b0, 0, 0);

    // Critical-word request on line 3
    issue(1'b0, 3, 2);
    collect_fill(3, 2, -1, 0, 1'b0, 0, 0);

    // Reset in the middle of a write-back after two beats
    issue(1'b1, 1, 0);
    wr_valid = 1'b1;
    wr_data  = 32'hdead0000;
    @(negedge clock);
    wr_data  = 32'hdead0001;
    @(negedge clock);
    wr_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check_idle("mid_wdata_reset");
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    check_idle("post_reset");
    issue(1'b0, 1, 0);
    collect_fill(1, 0, -1, 0, 1'b0, 0, 0);

    // Request held during a burst is taken right after the last beat
    issue(1'b0, 5, 1);
    collect_fill(5, 1, 2, 1, 1'b1, 6, 3);
    collect_fill(6, 3, -1, 0, 1'b0, 0, 0);

    // Randomized mix of fills and write-backs
    for (int t = 0; t < 24; t++) begin
      blk  = $urandom_range(0, 15);
      word = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < BW; k++) d[k] = $urandom;
        do_write(blk, d);
      end else begin
        issue(1'b0, blk, word);
        collect_fill(blk, word, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 0, 0);
      end
    end

    check_idle("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 The module SHALL take parameter DATA_W, default 32, word width in bits.
REQ-002 The module SHALL take parameter DEPTH, default 64, memory size in words.
REQ-003 The module SHALL take parameter BLK_WORDS, default 4, words per cache line.
REQ-004 The module SHALL take parameter LATENCY, default 3, cycles from request accept to first read beat or write ack (range 1..15).
REQ-005 The module SHALL have port `clock`, input, 1 bit: single clock, rising edge.
REQ-006 The module SHALL have port `reset`, input, 1 bit: asynchronous, active-low.
REQ-007 The module SHALL have the following request-channel ports:
- req_valid, input, 1 bit.
- req_ready, output, 1 bit.
- req_we, input, 1 bit: 1 means line write-back, 0 means line fill.
- req_blk, input, log2(DEPTH/BLK_WORDS) bits: line address.
- req_word, input, log2(BLK_WORDS) bits: critical word offset.
REQ-008 The module SHALL have the following write-beat ports:
- wr_valid, input, 1 bit.
- wr_ready, output, 1 bit.
- wr_data, input, DATA_W bits.
REQ-009 The module SHALL have the following read-beat ports:
- rsp_valid, output, 1 bit.
- rsp_ready, input, 1 bit.
- rsp_data, output, DATA_W bits.
- rsp_last, output, 1 bit.
REQ-010 The module SHALL have port wr_ack, output, 1 bit: one-cycle pulse when a write-back line is committed.

Function
REQ-011 The module SHALL implement an FSM with states IDLE, WDATA, WAIT and RBURST.
REQ-012 In IDLE, req_ready SHALL be 1 and all other outputs SHALL be 0.
REQ-013 A request SHALL be accepted on a clock edge where req_valid and req_ready are both 1, latching req_we, req_blk and req_word.
REQ-014 Write-back path: on accept the FSM SHALL enter WDATA with wr_ready=1.
REQ-015 In WDATA, each wr_valid&&wr_ready beat SHALL write wr_data to word req_blk*BLK_WORDS+k, with k counting 0..BLK_WORDS-1.
REQ-016 After the BLK_WORDS-th write beat the FSM SHALL enter WAIT.
REQ-017 Write-back path: after LATENCY cycles in WAIT, wr_ack SHALL pulse for 1 cycle and the FSM SHALL return to IDLE.
REQ-018 Fill path: on accept the FSM SHALL enter WAIT.
REQ-019 Fill path: after LATENCY cycles the FSM SHALL enter RBURST and present the first beat.
REQ-020 In RBURST, rsp_data SHALL hold steady while rsp_valid&&!rsp_ready, and the beat SHALL advance only on handshake.
REQ-021 rsp_last SHALL be 1 on the BLK_WORDS-th beat; its handshake SHALL return the FSM to IDLE.
REQ-022 Beat order without RESP_CWF_EN SHALL be word 0..BLK_WORDS-1; req_word SHALL be ignored.
REQ-023 The in-line beat index SHALL wrap modulo BLK_WORDS.
REQ-024 Memory read SHALL be registered, with rsp_data valid in the same cycle as rsp_valid.
REQ-025 A new request SHALL be accepted no earlier than the cycle after returning to IDLE, with no back-to-back accept.
REQ-026 wr_valid outside WDATA SHALL be ignored.
REQ-027 rsp_ready outside RBURST SHALL be ignored.
REQ-028 The latency counter SHALL be log2(16) bits and SHALL load LATENCY-1 on entry to WAIT.

Reset
REQ-029 Reset assertion SHALL force IDLE and SHALL clear every counter, all output registers, and wr_ack.
REQ-030 Reset SHALL initialise memory[i] = i for all i.
REQ-031 Reset asserted mid-burst SHALL abandon the transfer; partially written words SHALL be overwritten by the init values.

Configuration
REQ-032 When RESP_CWF_EN is defined, reads SHALL be critical-word-first: beat n returns word (req_word+n) mod BLK_WORDS, and rsp_last SHALL still mark the BLK_WORDS-th beat.
REQ-033 When RESP_CWF_EN is undefined, the ordering of REQ-022 SHALL apply and the req_word port SHALL remain present but unused.

Structure
REQ-034 Package line_mem_pkg SHALL hold the FSM state enum and the localparams BLK_W = log2(DEPTH/BLK_WORDS) and OFF_W = log2(BLK_WORDS).
REQ-035 The storage array SHALL be a sub-module `word_ram`: single port, synchronous read, write-enable, reset init of REQ-030.

Verification
REQ-036 The bench SHALL cover a fill: req_we=0, req_blk=2, LATENCY=3, rsp_ready=1 -> rsp_valid first at cycle 4 after accept, data 8,9,10,11, rsp_last on 11.
REQ-037 The bench SHALL cover a write-back: req_we=1, req_blk=1, beats 100,101,102,103 -> memory[4..7]=100..103, wr_ack 3 cycles after the last beat, then IDLE.
REQ-038 The bench SHALL cover backpressure: a fill of req_blk=0 with rsp_ready low for 2 cycles on beat 1 -> rsp_data holds at 1, with no skipped or duplicated beat.
REQ-039 The bench SHALL cover critical-word-first with RESP_CWF_EN: req_blk=3, req_word=2 -> 14,15,12,13, rsp_last on 13. Without RESP_CWF_EN -> 12,13,14,15.
REQ-040 The bench SHALL cover reset mid-WDATA after 2 beats -> req_ready=1, memory[4]=4, and the next fill of req_blk=1 returns 4,5,6,7.
REQ-041 The bench SHALL cover request during busy: req_valid held during RBURST -> req_ready=0, accepted exactly 1 cycle after the rsp_last handshake.
